// File: rtl/int_stack_controller_pkg.sv
// Shared types and constants for the interrupt stack controller.
package int_stack_controller_pkg;

  typedef enum logic [3:0] {
    IDLE,
    E_PCH,
    E_PCL,
    E_CCR,
    E_JMP,
    R_CCR,
    R_PCL,
    R_PCH,
    R_JMP
  } state_t;

  localparam logic [1:0] STEP_0 = 2'd0;
  localparam logic [1:0] STEP_1 = 2'd1;
  localparam logic [1:0] STEP_2 = 2'd2;
  localparam logic [1:0] STEP_3 = 2'd3;

  localparam logic [31:0] SP_RESET_DEFAULT = 32'h0000_07FF;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with +/-1 update, modulo 2^32.
// One-cycle update; inc and dec are never requested together.
module stack_pointer
  import int_stack_controller_pkg::*;
#(
  parameter logic [31:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  output logic [31:0] sp,
  output logic [31:0] sp_inc
);

  assign sp_inc = sp + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp <= SP_RESET;
    end else if (inc) begin
      sp <= sp_inc;
    end else if (dec) begin
      sp <= sp - 32'd1;
    end
  end

endmodule

// File: rtl/int_stack_controller.sv
// Interrupt entry/return sequencer: saves PC and CCR on the data stack, jumps to the ISR, restores on rti.
// Entry and return each take 4 stall cycles; no backpressure, memory stage accepts one access per cycle.
module int_stack_controller
  import int_stack_controller_pkg::*;
#(
  parameter logic [31:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        rti,
  input  logic [31:0] pc_in,
  input  logic [2:0]  ccr_in,
  input  logic [31:0] isr_addr,
  input  logic [15:0] mem_rdata,
  output logic        push,
  output logic        pop,
  output logic [31:0] sp_addr,
  output logic [15:0] wdata,
  output logic [1:0]  counter,
  output logic        int_sig,
  output logic        stall,
  output logic        pc_load,
  output logic [31:0] pc_value,
  output logic        ccr_load,
  output logic [2:0]  ccr_value,
  output logic        stack_err
);

  state_t      state;
  logic        pending;
  logic        in_isr;
  logic [15:0] pc_lo;
  logic [2:0]  ccr_sav;
  logic [31:0] sp;
  logic [31:0] sp_inc;

  stack_pointer #(.SP_RESET(SP_RESET)) u_sp (
    .clk    (clk),
    .rst    (rst),
    .inc    (pop),
    .dec    (push),
    .sp     (sp),
    .sp_inc (sp_inc)
  );

  // Push is post-decrement (address SP), pop is pre-increment (address SP+1).
  assign sp_addr = pop ? sp_inc : sp;

  // Outputs are registered for the state being entered, so they line up with state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      in_isr    <= 1'b0;
      stack_err <= 1'b0;
      pc_lo     <= '0;
      ccr_sav   <= '0;
      push      <= 1'b0;
      pop       <= 1'b0;
      wdata     <= '0;
      counter   <= STEP_0;
      int_sig   <= 1'b0;
      stall     <= 1'b0;
      pc_load   <= 1'b0;
      pc_value  <= '0;
      ccr_load  <= 1'b0;
      ccr_value <= '0;
    end else begin
      push      <= 1'b0;
      pop       <= 1'b0;
      wdata     <= '0;
      counter   <= STEP_0;
      int_sig   <= 1'b0;
      stall     <= 1'b0;
      pc_load   <= 1'b0;
      pc_value  <= '0;
      ccr_load  <= 1'b0;
      ccr_value <= '0;
      pending   <= pending | int_req;

      if (pop && (sp == SP_RESET)) begin
        stack_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          // A pending request after R_JMP waits here one cycle so pc_in reflects the restored PC.
          if (rti && in_isr) begin
            state <= R_CCR;
            pop   <= 1'b1;
            stall <= 1'b1;
          end else if (pending && !in_isr) begin
            state   <= E_PCH;
            pending <= int_req;
            pc_lo   <= pc_in[15:0];
            ccr_sav <= ccr_in;
            push    <= 1'b1;
            wdata   <= pc_in[31:16];
            int_sig <= 1'b1;
            stall   <= 1'b1;
          end
        end
        E_PCH: begin
          state   <= E_PCL;
          push    <= 1'b1;
          wdata   <= pc_lo;
          counter <= STEP_1;
          int_sig <= 1'b1;
          stall   <= 1'b1;
        end
        E_PCL: begin
          state   <= E_CCR;
          push    <= 1'b1;
          wdata   <= {13'b0, ccr_sav};
          counter <= STEP_2;
          int_sig <= 1'b1;
          stall   <= 1'b1;
        end
        E_CCR: begin
          state    <= E_JMP;
          pc_load  <= 1'b1;
          pc_value <= isr_addr;
          counter  <= STEP_3;
          int_sig  <= 1'b1;
          stall    <= 1'b1;
        end
        E_JMP: begin
          state  <= IDLE;
          in_isr <= 1'b1;
        end
        R_CCR: begin
          state   <= R_PCL;
          ccr_sav <= mem_rdata[2:0];
          pop     <= 1'b1;
          counter <= STEP_1;
          stall   <= 1'b1;
        end
        R_PCL: begin
          state   <= R_PCH;
          pc_lo   <= mem_rdata;
          pop     <= 1'b1;
          counter <= STEP_2;
          stall   <= 1'b1;
        end
        R_PCH: begin
          state     <= R_JMP;
          pc_load   <= 1'b1;
          pc_value  <= {mem_rdata, pc_lo};
          ccr_load  <= 1'b1;
          ccr_value <= ccr_sav;
          counter   <= STEP_3;
          stall     <= 1'b1;
        end
        R_JMP: begin
          state  <= IDLE;
          in_isr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/int_stack_controller.md
INT_STACK_CONTROLLER -- requirements
Module: int_stack_controller

Interface
REQ-001 Parameter SP_RESET, default 32'h0000_07FF, is the stack pointer value after reset, i.e. the empty-stack top.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 int_req  in  1  external interrupt request, sampled each cycle, pulse or level.
REQ-005 rti  in  1  one-cycle pulse: return-from-interrupt instruction has reached the memory stage.
REQ-006 pc_in  in  32  next-instruction address, saved on interrupt entry.
REQ-007 ccr_in  in  3  current flag register (CCR), saved on interrupt entry.
REQ-008 isr_addr  in  32  interrupt service routine start address.
REQ-009 mem_rdata  in  16  data-memory read word, valid combinationally in the cycle pop=1.
REQ-010 push  out  1  data-memory write of wdata at sp_addr, toward the memory stage.
REQ-011 pop  out  1  data-memory read at sp_addr, toward the memory stage.
REQ-012 sp_addr  out  32  stack access address.
REQ-013 wdata  out  16  word pushed.
REQ-014 counter  out  2  step index of the current multi-cycle sequence, to the memory-stage counter input.
REQ-015 int_sig  out  1  high during an entry sequence, to the memory-stage interrupt input.
REQ-016 stall  out  1  freeze fetch/decode and the PC.
REQ-017 pc_load, pc_value  out  1/32  one-cycle PC redirect and its target.
REQ-018 ccr_load, ccr_value  out  1/3  one-cycle CCR restore and its value.
REQ-019 stack_err  out  1  sticky stack-underflow flag.

Function
REQ-020 States: IDLE, E_PCH, E_PCL, E_CCR, E_JMP, R_CCR, R_PCL, R_PCH, R_JMP; every state other than IDLE lasts exactly one cycle.
REQ-021 int_req=1 sets the pending flag; pending clears on entry into E_PCH.
REQ-022 In IDLE, rti=1 with in_isr=1 goes to R_CCR; otherwise pending=1 with in_isr=0 goes to E_PCH; otherwise the FSM stays in IDLE.
REQ-023 rti has priority over pending in the same cycle; the interrupt stays pending.
REQ-024 rti with in_isr=0 is ignored, with no stack access.
REQ-025 Entry: E_PCH pushes pc_in[31:16] (counter=0), E_PCL pushes the saved pc[15:0] (counter=1), E_CCR pushes {13'b0,ccr} (counter=2), E_JMP drives pc_load=1 with pc_value=isr_addr (counter=3) and sets in_isr.
REQ-026 pc_in and ccr_in are captured on the IDLE->E_PCH edge; later changes to them do not affect the pushed words.
REQ-027 Push is post-decrement: sp_addr=SP, and SP<=SP-1 after each push.
REQ-028 Pop is pre-increment: sp_addr=SP+1, and SP<=SP+1 after each pop.
REQ-029 Return: R_CCR pops the CCR (counter=0), R_PCL pops pc[15:0] (counter=1), R_PCH pops pc[31:16] (counter=2); R_JMP drives pc_load=1, ccr_load=1 and clears in_isr (counter=3).
REQ-030 int_req arriving while in_isr=1 stays pending and is serviced starting the cycle after R_JMP; there is no nesting.
REQ-031 stall=1 in every state other than IDLE; entry latency from int_req to pc_load is 5 cycles.
REQ-032 A pop issued when SP==SP_RESET sets stack_err; the SP then wraps modulo 2^32 and the sequence continues.
REQ-033 SP arithmetic is modulo 2^32 with no saturation.
REQ-034 push and pop are never both 1 in the same cycle.

Reset
REQ-035 rst=0 at a clock edge forces IDLE, SP=SP_RESET, and pending, in_isr and stack_err all 0, aborting any sequence in progress.
REQ-036 During reset all outputs are 0, except sp_addr, which equals SP_RESET.

Structure
REQ-037 A shared package holds the state enumeration, the counter step constants and the SP_RESET default.
REQ-038 The SP register and its +/-1 logic form one sub-module, stack_pointer.

Verification
REQ-039 pc_in=32'h0001_0020, ccr_in=3'b101, isr_addr=32'h100, int_req pulse -> pushes 16'h0001@7FF, 16'h0020@7FE, 16'h0005@7FD; pc_load with 32'h100 at cycle 5; SP=7FC.
REQ-040 rti after the REQ-039 entry, mem_rdata supplied from the model -> pops at 7FD, 7FE, 7FF; pc_value=32'h0001_0020, ccr_value=3'b101; SP=7FF.
REQ-041 int_req and rti in the same cycle while in_isr=1 -> the return sequence runs first, entry starts the cycle after R_JMP.
REQ-042 rti with in_isr=0 -> no push or pop, SP unchanged, stack_err=0.
REQ-043 rst=0 asserted during E_PCL -> next cycle IDLE, SP=7FF, stall=0, pending=0.
